// File: rtl/ladder_pkg.sv
// Shared types and default widths for the ladder-counter monitors.
package ladder_pkg;

    localparam int CUR_W   = 4;
    localparam int DELTA_W = 3;
    localparam int PCNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        RISE,
        FALL,
        RESYNC
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_STEP,
        ERR_PEAK,
        ERR_COUNT
    } err_code_t;

endpackage

// File: rtl/ladder_count_check.sv
// Running-count check for a ladder sample stream: +/-1 modulo 2**CUR_W by direction,
// equality on a hold sample, and zero on the very first sample after reset.
module ladder_count_check #(
    parameter int CUR_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_vld,
    input  logic             check_en,
    input  logic             hold,
    input  logic             dir,
    input  logic [CUR_W-1:0] prev_cnt,
    input  logic [CUR_W-1:0] count,
    output logic             count_err
);

    logic first;
    logic count_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            first <= 1'b1;
        end else if (in_vld) begin
            first <= 1'b0;
        end
    end

    // The +1/-1 sums are evaluated at CUR_W bits, so 15<->0 wraps naturally.
    always_comb begin
        count_ok = 1'b0;
        if (first) begin
            count_ok = (count == '0);
        end else if (hold) begin
            count_ok = (count == prev_cnt);
        end else if (dir) begin
            count_ok = (count == prev_cnt + 1'b1);
        end else begin
            count_ok = (count == prev_cnt - 1'b1);
        end
        count_err = check_en && !count_ok;
    end

endmodule

// File: rtl/ladder_decoder.sv
// Receive-side ladder decoder: tracks rise/fall phases, recovers the peak (delta),
// counts completed periods and reports STEP/PEAK/COUNT violations.
module ladder_decoder
    import ladder_pkg::*;
#(
    parameter int CUR_W   = ladder_pkg::CUR_W,
    parameter int DELTA_W = ladder_pkg::DELTA_W,
    parameter int PCNT_W  = ladder_pkg::PCNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_vld,
    input  logic [CUR_W-1:0]   in_current,
    input  logic               in_dir,
    input  logic [CUR_W-1:0]   in_count,
    output logic [DELTA_W-1:0] delta_out,
    output logic               delta_vld,
    output logic               locked,
    output logic [PCNT_W-1:0]  period_cnt,
    output logic               err,
    output logic [1:0]         err_code,
    output logic               err_sticky
);

    localparam logic [CUR_W-1:0] PEAK_MIN = CUR_W'(2);
    localparam logic [CUR_W-1:0] PEAK_MAX = CUR_W'(2**DELTA_W - 1);

    state_t           state, next_state;
    logic [CUR_W-1:0] prev_cur, prev_cnt;
    logic [DELTA_W-1:0] peak;
    logic             cur_up, cur_dn, peak_ok, hold;
    logic             step_err, peak_err, count_err, any_err;
    logic             capture, period_inc, clear_dvld;
    err_code_t        code;

    function automatic logic [PCNT_W-1:0] sat_inc(input logic [PCNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    ladder_count_check #(.CUR_W(CUR_W)) u_count_check (
        .clk      (clk),
        .reset    (reset),
        .in_vld   (in_vld),
        .check_en (state != RESYNC),
        .hold     (hold),
        .dir      (in_dir),
        .prev_cnt (prev_cnt),
        .count    (in_count),
        .count_err(count_err)
    );

    assign cur_up  = (in_current == prev_cur + 1'b1);
    assign cur_dn  = (in_current == prev_cur - 1'b1);
    assign peak_ok = (prev_cur >= PEAK_MIN) && (prev_cur <= PEAK_MAX);
    assign hold    = (state == IDLE) && in_dir && (in_current == '0);

    always_comb begin
        next_state = state;
        step_err   = 1'b0;
        peak_err   = 1'b0;
        capture    = 1'b0;
        period_inc = 1'b0;
        clear_dvld = 1'b0;
        case (state)
            IDLE: begin
                if (in_dir && in_current == '0) begin
                    next_state = IDLE;
                end else if (in_dir && in_current == CUR_W'(1)) begin
                    next_state = RISE;
                end else begin
                    step_err = 1'b1;
                end
            end
            RISE: begin
                if (in_dir && cur_up) begin
                    next_state = RISE;
                end else if (!in_dir && cur_dn) begin
                    if (peak_ok) begin
                        next_state = FALL;
                        capture    = 1'b1;
                    end else begin
                        peak_err = 1'b1;
                    end
                end else begin
                    step_err = 1'b1;
                end
            end
            FALL: begin
                if (!in_dir && cur_dn && prev_cur > CUR_W'(1)) begin
                    next_state = FALL;
                end else if (in_dir && in_current == CUR_W'(1) && prev_cur == CUR_W'(1)) begin
                    next_state = RISE;
                    period_inc = 1'b1;
                end else begin
                    step_err = 1'b1;
                end
            end
            default: begin
                // Waiting for a clean ladder entry; anything else is silently ignored.
                if (in_dir && in_current == CUR_W'(1)) begin
                    next_state = RISE;
                    clear_dvld = 1'b1;
                end else if (in_dir && in_current == '0) begin
                    next_state = IDLE;
                    clear_dvld = 1'b1;
                end
            end
        endcase

        any_err = peak_err || step_err || count_err;
        if (peak_err)       code = ERR_PEAK;
        else if (step_err)  code = ERR_STEP;
        else if (count_err) code = ERR_COUNT;
        else                code = ERR_NONE;

        if (any_err) begin
            next_state = RESYNC;
            capture    = 1'b0;
            period_inc = 1'b0;
            clear_dvld = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            prev_cur   <= '0;
            prev_cnt   <= '0;
            peak       <= '0;
            delta_vld  <= 1'b0;
            locked     <= 1'b0;
            period_cnt <= '0;
            err        <= 1'b0;
            err_code   <= ERR_NONE;
            err_sticky <= 1'b0;
        end else begin
            err <= 1'b0;
            if (in_vld) begin
                state    <= next_state;
                prev_cur <= in_current;
                prev_cnt <= in_count;
                locked   <= (next_state == RISE) || (next_state == FALL);
                if (capture) begin
                    peak      <= DELTA_W'(prev_cur);
                    delta_vld <= 1'b1;
                end
                if (clear_dvld) begin
                    delta_vld <= 1'b0;
                end
                if (period_inc) begin
                    period_cnt <= sat_inc(period_cnt);
                end
                if (any_err) begin
                    err        <= 1'b1;
                    err_code   <= code;
                    err_sticky <= 1'b1;
                end
            end
        end
    end

    assign delta_out = peak;

endmodule

// File: tb/tb_ladder_decoder.sv
// Directed bench for ladder_decoder: hand-computed expectations checked with immediate assertions.
module tb_ladder_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_vld = 1'b0;
    logic [3:0] in_current = '0;
    logic       in_dir = 1'b0;
    logic [3:0] in_count = '0;
    logic [2:0] delta_out;
    logic       delta_vld;
    logic       locked;
    logic [7:0] period_cnt;
    logic       err;
    logic [1:0] err_code;
    logic       err_sticky;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    ladder_decoder dut (
        .clk       (clk),
        .reset     (reset),
        .in_vld    (in_vld),
        .in_current(in_current),
        .in_dir    (in_dir),
        .in_count  (in_count),
        .delta_out (delta_out),
        .delta_vld (delta_vld),
        .locked    (locked),
        .period_cnt(period_cnt),
        .err       (err),
        .err_code  (err_code),
        .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, expected completion)");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic smp(input logic [3:0] c, input logic d, input logic [3:0] n);
        @(negedge clk);
        in_vld = 1'b1;
        in_current = c;
        in_dir = d;
        in_count = n;
        @(posedge clk);
        #1;
    endtask

    task automatic gap();
        @(negedge clk);
        in_vld = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic rst();
        @(negedge clk);
        reset = 1'b1;
        in_vld = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_delta_out"}, 32'(delta_out), 0);
        check({tag, "_delta_vld"}, 32'(delta_vld), 0);
        check({tag, "_locked"}, 32'(locked), 0);
        check({tag, "_period"}, 32'(period_cnt), 0);
        check({tag, "_err"}, 32'(err), 0);
        check({tag, "_err_code"}, 32'(err_code), 0);
        check({tag, "_sticky"}, 32'(err_sticky), 0);
    endtask

    initial begin
        logic [3:0] c;

        repeat (2) @(posedge clk);
        rst();
        check_reset_state("reset");

        // Delta = 3 ladder from reset
        smp(0, 1, 0);  check("d3_idle_locked", 32'(locked), 0);
        smp(1, 1, 1);  check("d3_enter_locked", 32'(locked), 1);
        smp(2, 1, 2);
        smp(3, 1, 3);  check("d3_pre_peak_dvld", 32'(delta_vld), 0);
        smp(2, 0, 2);
        check("d3_delta_out", 32'(delta_out), 3);
        check("d3_delta_vld", 32'(delta_vld), 1);
        check("d3_period_before", 32'(period_cnt), 0);
        smp(1, 0, 1);
        smp(1, 1, 2);  check("d3_period", 32'(period_cnt), 1);
        smp(2, 1, 3);
        check("d3_err", 32'(err), 0);
        check("d3_sticky", 32'(err_sticky), 0);

        // Back into FALL, then in_vld gaps change nothing
        smp(3, 1, 4);
        smp(2, 0, 3);
        smp(1, 0, 2);
        for (int i = 0; i < 5; i++) begin
            gap();
            check("gap_delta_out", 32'(delta_out), 3);
            check("gap_delta_vld", 32'(delta_vld), 1);
            check("gap_locked", 32'(locked), 1);
            check("gap_period", 32'(period_cnt), 1);
            check("gap_err", 32'(err), 0);
        end
        smp(1, 1, 3);  check("gap_resume_period", 32'(period_cnt), 2);
        // Falling away from peak 1 is a PEAK error; delta and period survive
        smp(0, 0, 2);
        check("peak1_err", 32'(err), 1);
        check("peak1_code", 32'(err_code), 2);
        check("peak1_delta_kept", 32'(delta_out), 3);
        check("peak1_locked", 32'(locked), 0);
        check("peak1_period_kept", 32'(period_cnt), 2);
        gap();
        check("peak1_err_pulse", 32'(err), 0);
        check("peak1_code_held", 32'(err_code), 2);
        check("peak1_sticky", 32'(err_sticky), 1);

        // Delta-0 hold
        rst();
        for (int i = 0; i < 20; i++) begin
            smp(0, 1, 0);
            check("hold_err", 32'(err), 0);
        end
        check("hold_dvld", 32'(delta_vld), 0);
        check("hold_locked", 32'(locked), 0);
        check("hold_sticky", 32'(err_sticky), 0);

        // Skip step from a clean ladder
        smp(1, 1, 1);  check("skip_enter_locked", 32'(locked), 1);
        smp(3, 1, 2);
        check("skip_err", 32'(err), 1);
        check("skip_code", 32'(err_code), 1);
        check("skip_locked", 32'(locked), 0);
        smp(7, 0, 9);
        check("resync_ignore_err", 32'(err), 0);
        check("resync_ignore_locked", 32'(locked), 0);
        smp(1, 1, 5);  check("resync_relock", 32'(locked), 1);
        smp(2, 1, 6);
        check("resync_locked", 32'(locked), 1);
        check("resync_err", 32'(err), 0);
        check("resync_sticky", 32'(err_sticky), 1);

        // Count-only fault on a legal delta=2 ladder, then rising wrap 15->0
        rst();
        smp(0, 1, 0);
        smp(1, 1, 1);
        smp(2, 1, 2);
        smp(1, 0, 3);
        check("cnt_err", 32'(err), 1);
        check("cnt_code", 32'(err_code), 3);
        check("cnt_no_capture", 32'(delta_vld), 0);
        check("cnt_locked", 32'(locked), 0);
        smp(1, 1, 15);
        smp(2, 1, 0);
        check("wrap_err", 32'(err), 0);
        check("wrap_locked", 32'(locked), 1);
        check("wrap_code_held", 32'(err_code), 3);
        smp(3, 1, 1);  check("wrap_next_err", 32'(err), 0);

        // Error precedence and first-sample rule
        rst();
        smp(0, 1, 0);
        smp(1, 1, 1);
        smp(0, 0, 5);  check("prec_peak_over_count", 32'(err_code), 2);
        rst();
        smp(0, 1, 0);
        smp(1, 1, 1);
        smp(3, 1, 7);  check("prec_step_over_count", 32'(err_code), 1);
        rst();
        smp(1, 1, 1);
        check("first_cnt_err", 32'(err), 1);
        check("first_cnt_code", 32'(err_code), 3);

        // Reset during FALL wins over a concurrent sample
        rst();
        smp(0, 1, 0);
        smp(1, 1, 1);
        smp(2, 1, 2);
        smp(1, 0, 1);
        check("d2_delta_out", 32'(delta_out), 2);
        check("d2_locked", 32'(locked), 1);
        @(negedge clk);
        reset = 1'b1;
        in_vld = 1'b1;
        in_current = 4'd0;
        in_dir = 1'b0;
        in_count = 4'd0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        in_vld = 1'b0;
        check_reset_state("rst_fall");

        // Period counter saturation
        rst();
        smp(0, 1, 0);
        smp(1, 1, 1);
        smp(2, 1, 2);
        smp(1, 0, 1);
        c = 4'd1;
        for (int i = 0; i < 260; i++) begin
            smp(1, 1, 4'(c + 4'd1));
            smp(2, 1, 4'(c + 4'd2));
            smp(1, 0, 4'(c + 4'd1));
            c = 4'(c + 4'd1);
            if (i == 9) check("sat_period_10", 32'(period_cnt), 10);
        end
        check("sat_period", 32'(period_cnt), 255);
        check("sat_sticky", 32'(err_sticky), 0);
        check("sat_delta", 32'(delta_out), 2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
